// File: rtl/dodge_render_if.sv
// dodge_render_if: video timing, game inputs and pixel/status outputs for the dodge renderer
interface dodge_render_if #(parameter int N_OBS = 3);
  logic                 ready;
  logic                 vsync;
  logic [10:0]          column_addr;
  logic [10:0]          row_addr;
  logic [10:0]          player_x;
  logic [11*N_OBS-1:0]  obs_begin_row;
  logic [11*N_OBS-1:0]  obs_end_row;
  logic [11*N_OBS-1:0]  obs_begin_col;
  logic [11*N_OBS-1:0]  obs_end_col;
  logic                 start;
  logic                 restart;
  logic                 gameover;
  logic                 red;
  logic                 green;
  logic                 blue;
  logic                 fail;
  logic [1:0]           lives;
  modport master (
    output ready, vsync, column_addr, row_addr, player_x,
    output obs_begin_row, obs_end_row, obs_begin_col, obs_end_col,
    output start, restart, gameover,
    input  red, green, blue, fail, lives
  );
  modport slave (
    input  ready, vsync, column_addr, row_addr, player_x,
    input  obs_begin_row, obs_end_row, obs_begin_col, obs_end_col,
    input  start, restart, gameover,
    output red, green, blue, fail, lives
  );
endinterface

// File: rtl/dodge_render.sv
// dodge_render: per-pixel colouring of player/obstacle boxes and per-frame collision/lives FSM
module dodge_render #(
  parameter int N_OBS      = 3,
  parameter int LIVES      = 3,
  parameter int PLAYER_W   = 40,
  parameter int PLAYER_TOP = 540,
  parameter int PLAYER_BOT = 580
) (
  input logic            clk,
  input logic            rst_n,
  dodge_render_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PLAY, FAIL, OVER} state_t;
  state_t           r_state, w_next;
  logic             r_vsync, r_hit, r_fail, w_hit;
  logic [1:0]       r_lives, w_lives;
  logic [2:0]       r_rgb, w_rgb;
  logic [N_OBS-1:0] w_obs;
  logic             w_frame_end, w_player, w_any, w_overlap;
  assign w_frame_end = r_vsync & ~bus.vsync;
  // right edge at 12 bits so a player near column 2047 does not wrap
  assign w_player = bus.row_addr >= 11'(PLAYER_TOP) && bus.row_addr < 11'(PLAYER_BOT) &&
                    bus.column_addr >= bus.player_x &&
                    {1'b0, bus.column_addr} < {1'b0, bus.player_x} + 12'(PLAYER_W);
  for (genvar i = 0; i < N_OBS; i++) begin : g_obs
    assign w_obs[i] = bus.row_addr >= bus.obs_begin_row[11*i +: 11] &&
                      bus.row_addr <  bus.obs_end_row[11*i +: 11] &&
                      bus.column_addr >= bus.obs_begin_col[11*i +: 11] &&
                      bus.column_addr <  bus.obs_end_col[11*i +: 11];
  end
  assign w_any     = |w_obs;
  assign w_overlap = w_player & w_any;
  always_comb begin
    w_next  = r_state;
    w_lives = r_lives;
    w_hit   = r_hit;
    if (bus.restart) begin
      w_next  = IDLE;
      w_lives = 2'(LIVES);
      w_hit   = 1'b0;
    end else begin
      w_hit = w_frame_end ? 1'b0 : (r_hit | (r_state == PLAY && bus.ready && w_overlap));
      if (w_frame_end && r_hit && r_state == PLAY)
        w_lives = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
      if (r_state == IDLE && bus.start)
        w_next = PLAY;
      else if (r_state == PLAY && w_frame_end && r_hit && r_lives <= 2'd1)
        w_next = FAIL;
      else if (r_state == PLAY && bus.gameover)
        w_next = OVER;
    end
  end
  always_comb begin
    w_rgb = !bus.ready         ? 3'b000 :
            r_state == FAIL    ? 3'b100 :
            r_state == OVER    ? 3'b011 :
            r_state == IDLE    ? {1'b0, w_player, 1'b0} :
            w_overlap          ? 3'b100 :
            w_player           ? 3'b010 :
            w_any              ? 3'b001 : 3'b000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vsync <= 1'b1;
      r_hit   <= 1'b0;
      r_fail  <= 1'b0;
      r_lives <= 2'(LIVES);
      r_rgb   <= 3'b000;
    end else begin
      r_state <= w_next;
      r_vsync <= bus.vsync;
      r_hit   <= w_hit;
      r_fail  <= (w_next == FAIL);
      r_lives <= w_lives;
      r_rgb   <= w_rgb;
    end
  end
  assign {bus.red, bus.green, bus.blue} = r_rgb;
  assign bus.fail  = r_fail;
  assign bus.lives = r_lives;
endmodule

// File: tb/tb_dodge_render.sv
// tb_dodge_render: directed-vector check of colouring, per-frame lives and FSM of dodge_render
module tb_dodge_render;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  dodge_render_if #(.N_OBS(3)) bus ();
  dodge_render dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] rgb();
    return {1'b0, bus.red, bus.green, bus.blue};
  endfunction
  task automatic pix(input logic [10:0] r, input logic [10:0] c, input logic rd);
    bus.row_addr = r;
    bus.column_addr = c;
    bus.ready = rd;
    @(posedge clk); #1;
  endtask
  task automatic frame();
    bus.ready = 1'b0;
    bus.vsync = 1'b0;
    @(posedge clk); #1;
    bus.vsync = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(posedge clk); #1;
    bus.restart = 1'b0;
  endtask
  task automatic set_obs0(input logic [10:0] br, input logic [10:0] er, input logic [10:0] bc, input logic [10:0] ec);
    bus.obs_begin_row[10:0] = br;
    bus.obs_end_row[10:0]   = er;
    bus.obs_begin_col[10:0] = bc;
    bus.obs_end_col[10:0]   = ec;
  endtask
  initial begin
    bus.ready = 1'b0; bus.vsync = 1'b1; bus.column_addr = '0; bus.row_addr = '0;
    bus.player_x = 11'd10; bus.start = 1'b0; bus.restart = 1'b0; bus.gameover = 1'b0;
    bus.obs_begin_row = '0; bus.obs_end_row = '0; bus.obs_begin_col = '0; bus.obs_end_col = '0;
    #12;
    chk("reset_rgb", rgb(), 4'h0);
    chk("reset_fail", {3'b0, bus.fail}, 4'h0);
    chk("reset_lives", {2'b0, bus.lives}, 4'd3);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pix(11'd560, 11'd20, 1'b1);   chk("idle_player", rgb(), 4'b010);
    pix(11'd100, 11'd100, 1'b1);  chk("idle_bg", rgb(), 4'b000);
    bus.player_x = 11'd2040;
    pix(11'd560, 11'd2045, 1'b1); chk("idle_wide_edge", rgb(), 4'b010);
    bus.player_x = 11'd10;
    pulse_start();
    pix(11'd560, 11'd20, 1'b1);   chk("play_player", rgb(), 4'b010);
    pix(11'd560, 11'd50, 1'b1);   chk("play_right_excl", rgb(), 4'b000);
    frame(); pix(11'd560, 11'd20, 1'b1); frame(); frame();
    chk("noobs_lives", {2'b0, bus.lives}, 4'd3);
    chk("noobs_fail", {3'b0, bus.fail}, 4'h0);
    set_obs0(11'd530, 11'd590, 11'd0, 11'd60);
    pix(11'd545, 11'd15, 1'b1);   chk("overlap_red", rgb(), 4'b100);
    pix(11'd545, 11'd50, 1'b1);   chk("obs_blue", rgb(), 4'b001);
    pix(11'd545, 11'd9, 1'b1);    chk("obs_left_blue", rgb(), 4'b001);
    pix(11'd539, 11'd20, 1'b1);   chk("obs_above_blue", rgb(), 4'b001);
    pix(11'd545, 11'd15, 1'b0);   chk("blank_black", rgb(), 4'b000);
    frame();
    chk("hit1_lives", {2'b0, bus.lives}, 4'd2);
    frame();
    chk("nohit_lives", {2'b0, bus.lives}, 4'd2);
    pix(11'd545, 11'd15, 1'b1); frame();
    chk("hit2_lives", {2'b0, bus.lives}, 4'd1);
    chk("hit2_fail", {3'b0, bus.fail}, 4'h0);
    pix(11'd545, 11'd15, 1'b1); frame();
    chk("hit3_lives", {2'b0, bus.lives}, 4'd0);
    chk("hit3_fail", {3'b0, bus.fail}, 4'h1);
    pix(11'd10, 11'd10, 1'b1);    chk("fail_red", rgb(), 4'b100);
    pix(11'd10, 11'd10, 1'b0);    chk("fail_blank", rgb(), 4'b000);
    pulse_start();
    pix(11'd10, 11'd10, 1'b1);    chk("fail_sticky", rgb(), 4'b100);
    pulse_restart();
    chk("restart_lives", {2'b0, bus.lives}, 4'd3);
    chk("restart_fail", {3'b0, bus.fail}, 4'h0);
    pix(11'd10, 11'd10, 1'b1);    chk("restart_idle_bg", rgb(), 4'b000);
    pulse_start();
    pix(11'd545, 11'd15, 1'b1); frame();
    pix(11'd545, 11'd15, 1'b1); frame();
    chk("race_pre_lives", {2'b0, bus.lives}, 4'd1);
    pix(11'd545, 11'd15, 1'b1);
    bus.gameover = 1'b1;
    frame();
    bus.gameover = 1'b0;
    chk("race_fail", {3'b0, bus.fail}, 4'h1);
    pix(11'd10, 11'd10, 1'b1);    chk("race_red", rgb(), 4'b100);
    pulse_restart();
    pulse_start();
    pix(11'd545, 11'd15, 1'b1); frame();
    chk("over_pre_lives", {2'b0, bus.lives}, 4'd2);
    pix(11'd545, 11'd15, 1'b1);
    bus.gameover = 1'b1;
    pix(11'd10, 11'd10, 1'b1);
    bus.gameover = 1'b0;
    pix(11'd10, 11'd10, 1'b1);    chk("over_cyan_bg", rgb(), 4'b011);
    pix(11'd560, 11'd20, 1'b1);   chk("over_cyan_player", rgb(), 4'b011);
    frame();
    chk("over_lives", {2'b0, bus.lives}, 4'd2);
    chk("over_fail", {3'b0, bus.fail}, 4'h0);
    pulse_restart();
    chk("restart2_lives", {2'b0, bus.lives}, 4'd3);
    pulse_start();
    set_obs0(11'd530, 11'd590, 11'd100, 11'd100);
    bus.player_x = 11'd90;
    pix(11'd560, 11'd100, 1'b1);  chk("empty_green", rgb(), 4'b010);
    frame();
    chk("empty_lives", {2'b0, bus.lives}, 4'd3);
    set_obs0(11'd530, 11'd590, 11'd0, 11'd60);
    bus.player_x = 11'd10;
    pix(11'd545, 11'd15, 1'b1); frame();
    chk("pre_rst_lives", {2'b0, bus.lives}, 4'd2);
    pix(11'd545, 11'd15, 1'b1);   chk("pre_rst_red", rgb(), 4'b100);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rgb", rgb(), 4'b000);
    chk("async_lives", {2'b0, bus.lives}, 4'd3);
    chk("async_fail", {3'b0, bus.fail}, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    frame();
    chk("post_rst_lives", {2'b0, bus.lives}, 4'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dodge_render.md
# dodge_render

Pixel renderer and collision judge for the dodge game, sitting directly downstream of the VGA sync generator and the falling-square position registers. Each pixel clock it colours the current pixel from the player box and up to `N_OBS` obstacle boxes. It flags per-frame player/obstacle overlap and spends one life per hit frame. It produces `fail`, which freezes the round timer and resets the squares.

## Interface
- `N_OBS`, 3 — number of obstacle boxes.
- `LIVES`, 3 — lives loaded on reset/restart (1..3).
- `PLAYER_W`, 40 — player box width in pixels.
- `PLAYER_TOP`, 540 — player box first row.
- `PLAYER_BOT`, 580 — player box row bound (exclusive).
- `clk`  in  1  pixel clock (40 MHz VGA clock).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ready`  in  1  active-video flag from sync stage.
- `vsync`  in  1  vertical sync, active-low.
- `column_addr`  in  11  pixel column, 0..799 when `ready`.
- `row_addr`  in  11  pixel row, 0..599 when `ready`.
- `player_x`  in  11  player box left column.
- `obs_begin_row`, `obs_end_row`  in  11*N_OBS  obstacle row bounds; slice i = bits [11i+10:11i].
- `obs_begin_col`, `obs_end_col`  in  11*N_OBS  obstacle column bounds, same packing.
- `start`  in  1  level; leave IDLE.
- `restart`  in  1  level/pulse, synchronous to `clk`; return to IDLE.
- `gameover`  in  1  level; timer expired.
- `red`, `green`, `blue`  out  1 each  pixel colour, registered.
- `fail`  out  1  high in FAIL state.
- `lives`  out  2  remaining lives.

## Operation
- Box membership is half-open on both axes: `begin <= addr < end`, 11-bit unsigned compares.
- Player: rows `PLAYER_TOP <= row < PLAYER_BOT`; columns `player_x <= col < player_x+PLAYER_W`. The right edge is computed at 12 bits, with no wrap and no clamp.
- An obstacle with `end <= begin` on either axis is empty and never matches.
- Frame boundary is the falling edge of `vsync`: `vsync` is registered, and `frame_end = prev & ~vsync`.
- FSM states: IDLE, PLAY, FAIL, OVER. Reset state is IDLE.
- `restart` has the highest priority: from any state it goes to IDLE, reloads `lives`, and clears `hit_frame`.
- IDLE -> PLAY when `start`=1.
- PLAY -> OVER when `gameover`=1.
- PLAY -> FAIL at `frame_end` when the life decrement reaches 0. If `gameover` is asserted on the same cycle, FAIL wins.
- FAIL and OVER are sticky until `restart`.
- `hit_frame` sets when state=PLAY and `ready` and the pixel lies in the player box and in any obstacle box. It stays set for the rest of the frame.
- At `frame_end`, if `hit_frame` then `lives` decrements, saturating at 0. `hit_frame` clears at every `frame_end`.
- Effect: at most one life is lost per frame, regardless of overlap size.
- Colour when `ready`=0: black in every state.
- Colour in IDLE: player green, everything else black.
- Colour in PLAY, first match wins:
  - overlap pixel: red;
  - player: green;
  - obstacle: blue;
  - background: black.
- Colour in FAIL: whole active area red.
- Colour in OVER: whole active area cyan (0,1,1).

## Timing
- Reset values: `red=green=blue=0`, `fail=0`, `lives=LIVES`, state IDLE, `hit_frame=0`, registered vsync = 1.
- RGB latency: exactly 1 clock from `column_addr`/`row_addr`/`ready`. The pipeline is registered compare, no extra stage.
- `fail` is registered and asserts the cycle after the PLAY->FAIL transition edge (1 clock after `frame_end` is seen).
- `lives` updates on the same edge as the FSM.
- State change takes effect on the colour of the next pixel.
- Reset mid-frame: outputs go to reset values immediately (asynchronous). The first `frame_end` after release uses a clean `hit_frame`.
- `start` in PLAY/FAIL/OVER is ignored. `gameover` outside PLAY is ignored.

## Test plan
- Reset, then `start`=1 with no obstacles overlapping player; run 3 frames -> `lives`=3, `fail`=0. Pixel (560, 20) with `player_x`=10 renders green 1 clock later.
- Obstacle 0 at rows 530..590, cols 0..60, `player_x`=10, PLAY for 1 frame -> `lives` 3->2 at `frame_end`. Pixel (545, 15) renders red; pixel (545, 50) renders blue.
- Overlap held for 3 consecutive frames from `lives`=3 -> `lives` 2, 1, 0. FSM enters FAIL and `fail`=1 one clock after the third `frame_end`. Active pixels render red; `ready`=0 pixels render black.
- Last-life hit with `gameover`=1 on the `frame_end` cycle -> FAIL, not OVER.
- `gameover`=1 in PLAY -> OVER, cyan screen, `lives` unchanged. Then `restart` pulse -> IDLE, `lives`=3, `fail`=0. Then `start` -> PLAY.
- Empty obstacle (begin_col=100, end_col=100) over player -> no hit, `lives` stays 3. Then `rst_n` low mid-frame -> RGB 0 and `lives`=3 immediately.
